// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported, fixed-latency unified memory between
//            the instruction-fetch (I) port and the data (D) port. Arbitrates
//            with a bounded data-streak rule, sequences each multi-cycle
//            access, formats byte/half loads and stores, and produces per-port
//            stall signals for the hazard logic.
// Ports    : Clk, Reset            - clock (rising edge), async active-high reset
//            I_Req/I_Addr          - fetch request and word byte address
//            I_Ack/I_RData/I_Stall - fetch completion pulse, fetched word, stall
//            D_RReq/D_WReq         - load / store request (store wins if both)
//            D_Addr/D_WData        - data byte address, store data
//            D_RWidth/D_WWidth     - 0=word, 1=half, 2=byte, 3=illegal
//            D_Ack/D_RData/D_Stall - data completion pulse, load result, stall
//            Misalign              - pulses with D_Ack when an access was dropped
//            M_En/M_WE/M_ByteEn    - memory enable, write strobe, lane enables
//            M_Addr/M_WData        - word-aligned address, lane-replicated data
//            M_RData               - memory read word
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        I_Req,
    input  logic [31:0] I_Addr,
    output logic        I_Ack,
    output logic [31:0] I_RData,
    output logic        I_Stall,
    input  logic        D_RReq,
    input  logic        D_WReq,
    input  logic [31:0] D_Addr,
    input  logic [31:0] D_WData,
    input  logic [1:0]  D_RWidth,
    input  logic [1:0]  D_WWidth,
    output logic        D_Ack,
    output logic [31:0] D_RData,
    output logic        D_Stall,
    output logic        Misalign,
    output logic        M_En,
    output logic        M_WE,
    output logic [3:0]  M_ByteEn,
    output logic [31:0] M_Addr,
    output logic [31:0] M_WData,
    input  logic [31:0] M_RData
);

    localparam int              c_SW         = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [c_SW-1:0] c_STREAK_MAX = c_SW'(MAX_DATA_STREAK);
    localparam logic [1:0]      c_LAT_INIT   = 2'(MEM_LATENCY - 1);

    localparam logic [1:0] c_W_WORD = 2'd0;
    localparam logic [1:0] c_W_HALF = 2'd1;
    localparam logic [1:0] c_W_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_cnt;
    logic [c_SW-1:0]   r_streak;
    logic              r_owner_d;     // 1: data port owns the access
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_width;
    logic              r_rw;          // 1: store
    logic              r_misalign;
    logic [31:0]       r_i_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_d_req;
    logic              w_grant_d;
    logic              w_grant_i;
    logic [1:0]        w_d_width;
    logic              w_d_illegal;
    logic [3:0]        w_lane_en;
    logic [31:0]       w_wdata_rep;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // ------------------------------------------------------------------
    // Arbitration: data wins unless it has monopolised the memory for
    // MAX_DATA_STREAK grants while a fetch was waiting.
    // ------------------------------------------------------------------
    assign w_d_req   = D_RReq | D_WReq;
    assign w_grant_d = (r_state == ST_IDLE) && w_d_req &&
                       ((r_streak < c_STREAK_MAX) || !I_Req);
    assign w_grant_i = (r_state == ST_IDLE) && !w_grant_d && I_Req;

    // A simultaneous load+store request is treated as a store.
    assign w_d_width = D_WReq ? D_WWidth : D_RWidth;

    always_comb begin
        w_d_illegal = 1'b0;
        case (w_d_width)
            c_W_WORD: w_d_illegal = (D_Addr[1:0] != 2'b00);
            c_W_HALF: w_d_illegal = D_Addr[0];
            c_W_BYTE: w_d_illegal = 1'b0;
            default:  w_d_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane steering from the latched access
    // ------------------------------------------------------------------
    always_comb begin
        w_lane_en   = 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_width)
            c_W_WORD: w_lane_en = 4'b1111;
            c_W_HALF: begin
                w_lane_en   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            c_W_BYTE: begin
                w_lane_en   = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            default: w_lane_en = 4'b0000;
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = M_RData[7:0];
            2'd1:    w_byte = M_RData[15:8];
            2'd2:    w_byte = M_RData[23:16];
            default: w_byte = M_RData[31:24];
        endcase
        w_half = r_addr[1] ? M_RData[31:16] : M_RData[15:0];
        case (r_width)
            c_W_HALF: w_load = {{16{w_half[15]}}, w_half};
            c_W_BYTE: w_load = {{24{w_byte[7]}}, w_byte};
            default:  w_load = M_RData;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        M_En         = 1'b0;
        M_WE         = 1'b0;
        M_ByteEn     = 4'b0000;
        M_Addr       = 32'd0;
        M_WData      = 32'd0;
        I_Ack        = 1'b0;
        D_Ack        = 1'b0;
        Misalign     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    // Dropped accesses skip the memory and answer next cycle.
                    w_next_state = w_d_illegal ? ST_RESP : ST_BUSY;
                end else if (w_grant_i) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                M_En     = 1'b1;
                M_ByteEn = w_lane_en;
                M_Addr   = {r_addr[31:2], 2'b00};
                M_WData  = w_wdata_rep;
                // Write strobe only in the last cycle so the memory commits once.
                M_WE     = r_rw && (r_cnt == 2'd0);
                if (r_cnt == 2'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                I_Ack        = !r_owner_d;
                D_Ack        = r_owner_d;
                Misalign     = r_owner_d && r_misalign;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign I_Stall = I_Req & ~I_Ack;
    assign D_Stall = w_d_req & ~D_Ack;
    assign I_RData = r_i_rdata;
    assign D_RData = r_d_rdata;

    // ------------------------------------------------------------------
    // Access latching, latency counter, streak counter, read data
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt      <= 2'd0;
            r_streak   <= '0;
            r_owner_d  <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_width    <= 2'd0;
            r_rw       <= 1'b0;
            r_misalign <= 1'b0;
            r_i_rdata  <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_owner_d  <= 1'b1;
                        r_addr     <= D_Addr;
                        r_wdata    <= D_WData;
                        r_width    <= w_d_width;
                        r_rw       <= D_WReq;
                        r_misalign <= w_d_illegal;
                        r_cnt      <= c_LAT_INIT;
                        if (w_d_illegal) begin
                            r_d_rdata <= 32'd0;
                        end
                        if (I_Req) begin
                            if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end else if (w_grant_i) begin
                        r_owner_d  <= 1'b0;
                        r_addr     <= I_Addr;
                        r_wdata    <= 32'd0;
                        r_width    <= c_W_WORD;
                        r_rw       <= 1'b0;
                        r_misalign <= 1'b0;
                        r_cnt      <= c_LAT_INIT;
                        r_streak   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else if (!r_rw) begin
                        if (r_owner_d) begin
                            r_d_rdata <= w_load;
                        end else begin
                            r_i_rdata <= w_load;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            model (grant cycle + elapsed-cycle arithmetic) predicts every
//            output each cycle; directed tasks pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L    = 2;
    localparam int MAXS = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        I_Req = 1'b0;
    logic [31:0] I_Addr = 32'd0;
    logic        I_Ack;
    logic [31:0] I_RData;
    logic        I_Stall;
    logic        D_RReq = 1'b0;
    logic        D_WReq = 1'b0;
    logic [31:0] D_Addr = 32'd0;
    logic [31:0] D_WData = 32'd0;
    logic [1:0]  D_RWidth = 2'd0;
    logic [1:0]  D_WWidth = 2'd0;
    logic        D_Ack;
    logic [31:0] D_RData;
    logic        D_Stall;
    logic        Misalign;
    logic        M_En;
    logic        M_WE;
    logic [3:0]  M_ByteEn;
    logic [31:0] M_Addr;
    logic [31:0] M_WData;
    logic [31:0] M_RData = 32'd0;

    mem_port_arbiter #(.MEM_LATENCY(L), .MAX_DATA_STREAK(MAXS)) dut (
        .Clk(Clk), .Reset(Reset),
        .I_Req(I_Req), .I_Addr(I_Addr), .I_Ack(I_Ack), .I_RData(I_RData), .I_Stall(I_Stall),
        .D_RReq(D_RReq), .D_WReq(D_WReq), .D_Addr(D_Addr), .D_WData(D_WData),
        .D_RWidth(D_RWidth), .D_WWidth(D_WWidth), .D_Ack(D_Ack), .D_RData(D_RData),
        .D_Stall(D_Stall), .Misalign(Misalign),
        .M_En(M_En), .M_WE(M_WE), .M_ByteEn(M_ByteEn), .M_Addr(M_Addr),
        .M_WData(M_WData), .M_RData(M_RData)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] wd);
        logic [31:0] v;
        if (wd == 2'd2) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (wd == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] be_of(input logic own_d, input logic [1:0] wd,
                                         input logic [31:0] a);
        if (!own_d || wd == 2'd0) return 4'hF;
        if (wd == 2'd1) return a[1] ? 4'hC : 4'h3;
        return 4'(1 << a[1:0]);
    endfunction

    function automatic logic [31:0] rep(input logic [1:0] wd, input logic [31:0] d);
        if (wd == 2'd1) return {2{d[15:0]}};
        if (wd == 2'd2) return {4{d[7:0]}};
        return d;
    endfunction

    int          cyc = 0;
    bit          m_busy = 1'b0;
    int          m_g = 0;
    bit          m_owner_d, m_store, m_illegal;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_width;
    int          m_streak = 0;
    logic [31:0] m_irdata = 32'd0, m_drdata = 32'd0, m_pend = 32'd0;

    logic        e_en, e_we, e_iack, e_dack, e_mis, e_chk_wd;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    int          k;
    int          we_total = 0, ack_total = 0;

    always @(negedge Clk) begin
        cyc++;
        e_en = 0; e_we = 0; e_iack = 0; e_dack = 0; e_mis = 0; e_chk_wd = 0;
        e_be = 4'h0; e_addr = 32'd0; e_wd = 32'd0;
        if (Reset) begin
            m_busy = 0; m_streak = 0; m_irdata = 32'd0; m_drdata = 32'd0;
        end else if (!m_busy) begin
            if ((D_RReq || D_WReq) && (m_streak < MAXS || !I_Req)) begin
                m_busy = 1; m_g = cyc; m_owner_d = 1; m_store = D_WReq;
                m_width = D_WReq ? D_WWidth : D_RWidth;
                m_addr = D_Addr; m_wdata = D_WData;
                m_illegal = (m_width == 2'd3) || (m_width == 2'd0 && D_Addr % 4 != 0) ||
                            (m_width == 2'd1 && D_Addr % 2 != 0);
                m_streak = I_Req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else if (I_Req) begin
                m_busy = 1; m_g = cyc; m_owner_d = 0; m_store = 0; m_width = 2'd0;
                m_addr = I_Addr; m_wdata = 32'd0; m_illegal = 0; m_streak = 0;
            end
        end else begin
            k = cyc - m_g;
            if (m_illegal) begin
                e_dack = 1; e_mis = 1; m_drdata = 32'd0; m_busy = 0;
            end else if (k <= L) begin
                e_en = 1; e_addr = m_addr & 32'hFFFF_FFFC;
                e_be = be_of(m_owner_d, m_width, m_addr);
                e_we = m_store && (k == L);
                if (m_store) begin e_chk_wd = 1; e_wd = rep(m_width, m_wdata); end
                if (k == L && !m_store) m_pend = load_fmt(M_RData, m_addr, m_width);
            end else begin
                if (m_owner_d) begin
                    e_dack = 1;
                    if (!m_store) m_drdata = m_pend;
                end else begin
                    e_iack = 1; m_irdata = m_pend;
                end
                m_busy = 0;
            end
        end
        chk("m_en", M_En, e_en);
        chk("m_we", M_WE, e_we);
        chk("m_byteen", M_ByteEn, e_be);
        if (e_en) chk("m_addr", M_Addr, e_addr);
        if (e_chk_wd) chk("m_wdata", M_WData, e_wd);
        chk("i_ack", I_Ack, e_iack);
        chk("d_ack", D_Ack, e_dack);
        chk("misalign", Misalign, e_mis);
        chk("i_rdata", I_RData, m_irdata);
        chk("d_rdata", D_RData, m_drdata);
        chk("i_stall", I_Stall, I_Req & ~e_iack);
        chk("d_stall", D_Stall, (D_RReq | D_WReq) & ~e_dack);
        if (M_WE) we_total++;
        if (I_Ack || D_Ack) ack_total++;
    end

    // ---------------- directed stimulus ----------------
    int          t_lat, t_en, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_wd, t_maddr, t_rdata;
    logic        t_mis;

    // Called just after a rising edge; the request cycle is the grant cycle.
    task automatic access(input bit is_i, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] width);
        t_lat = -1; t_en = 0; t_we = 0; t_be = 4'h0; t_wd = 0; t_maddr = 0;
        t_rdata = 0; t_mis = 0;
        if (is_i) begin
            I_Req = 1; I_Addr = addr;
        end else begin
            D_RReq = rd; D_WReq = wr; D_Addr = addr; D_WData = wd;
            D_RWidth = width; D_WWidth = width;
        end
        for (int n = 0; n < 40 && t_lat < 0; n++) begin
            @(negedge Clk);
            if (M_En) begin t_en++; t_maddr = M_Addr; end
            if (M_WE) begin t_we++; t_be = M_ByteEn; t_wd = M_WData; end
            if (is_i ? I_Ack : D_Ack) begin
                t_lat = n; t_rdata = is_i ? I_RData : D_RData; t_mis = Misalign;
            end
        end
        @(posedge Clk); #1;
        I_Req = 0; D_RReq = 0; D_WReq = 0;
        chk("ack_seen", 32'(t_lat >= 0), 32'd1);
    endtask

    // Both ports request continuously; pat bit i = 1 when grant i must be data.
    task automatic streak_run(input int n, input string tag, input logic [9:0] pat);
        int got, run, maxrun;
        got = 0; run = 0; maxrun = 0;
        I_Req = 1; I_Addr = 32'h80; D_RReq = 1; D_WReq = 0; D_Addr = 32'h20;
        D_RWidth = 2'd0; M_RData = 32'h0BAD_F00D;
        for (int c = 0; c < 200 && got < n; c++) begin
            @(negedge Clk);
            run = I_Stall ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (D_Ack || I_Ack) begin
                chk($sformatf("%s_grant%0d", tag, got), 32'(D_Ack), 32'(pat[got]));
                got++;
            end
        end
        @(posedge Clk); #1;
        I_Req = 0; D_RReq = 0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_istall_bound"}, 32'(maxrun <= 4 * (L + 2) + L + 2), 32'd1);
    endtask

    initial begin
        int got, w0, a0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_m_en", M_En, 0);
        chk("rst_d_ack", D_Ack, 0);
        chk("rst_i_rdata", I_RData, 0);
        chk("rst_d_rdata", D_RData, 0);
        @(posedge Clk); #1;
        Reset = 0;

        // fetch
        M_RData = 32'h1234_5678;
        access(1, 0, 0, 32'h40, 0, 2'd0);
        chk("ifetch_lat", t_lat, 3);
        chk("ifetch_en_cycles", t_en, 2);
        chk("ifetch_maddr", t_maddr, 32'h40);
        chk("ifetch_rdata", t_rdata, 32'h1234_5678);

        // sign-extended loads
        M_RData = 32'h80FF_0000;
        access(0, 1, 0, 32'h103, 0, 2'd2);
        chk("lb_103", t_rdata, 32'hFFFF_FF80);
        chk("lb_lat", t_lat, 3);
        access(0, 1, 0, 32'h102, 0, 2'd1);
        chk("lh_102", t_rdata, 32'hFFFF_80FF);
        M_RData = 32'h7F00_ABCD;
        access(0, 1, 0, 32'h103, 0, 2'd2);
        chk("lb_pos", t_rdata, 32'h0000_007F);
        access(0, 1, 0, 32'h100, 0, 2'd1);
        chk("lh_100", t_rdata, 32'hFFFF_ABCD);
        access(0, 1, 0, 32'h104, 0, 2'd0);
        chk("lw_104", t_rdata, 32'h7F00_ABCD);

        // stores
        access(0, 0, 1, 32'h206, 32'hAAAA_BEEF, 2'd1);
        chk("sh_we_cycles", t_we, 1);
        chk("sh_byteen", t_be, 4'b1100);
        chk("sh_wdata", t_wd, 32'hBEEF_BEEF);
        chk("sh_maddr", t_maddr, 32'h204);
        chk("sh_drdata_kept", D_RData, 32'h7F00_ABCD);
        access(0, 0, 1, 32'h201, 32'h1234_565A, 2'd2);
        chk("sb_byteen", t_be, 4'b0010);
        chk("sb_wdata", t_wd, 32'h5A5A_5A5A);
        access(0, 1, 1, 32'h10, 32'hCAFE_F00D, 2'd0);
        chk("rw_both_we", t_we, 1);
        chk("rw_both_be", t_be, 4'hF);

        // dropped accesses
        access(0, 1, 0, 32'h101, 0, 2'd0);
        chk("mis_w_en", t_en, 0);
        chk("mis_w_lat", t_lat, 1);
        chk("mis_w_flag", t_mis, 1);
        chk("mis_w_rdata", t_rdata, 0);
        access(0, 1, 0, 32'h100, 0, 2'd3);
        chk("mis_w3_flag", t_mis, 1);
        access(0, 0, 1, 32'h103, 32'h55, 2'd1);
        chk("mis_h_flag", t_mis, 1);
        chk("mis_h_we", t_we, 0);

        // streak fairness
        streak_run(10, "streak", 10'b0111101111);

        // reset during the second BUSY cycle of a store, with streak at 3
        I_Req = 1; I_Addr = 32'h80; D_RReq = 1; D_Addr = 32'h20; D_RWidth = 2'd0;
        got = 0;
        for (int c = 0; c < 50 && got < 2; c++) begin
            @(negedge Clk);
            if (D_Ack) got++;
        end
        chk("pre_rst_d_acks", got, 2);
        @(posedge Clk); #1;
        D_RReq = 0; D_WReq = 1; D_Addr = 32'h300; D_WData = 32'h1122_3344; D_WWidth = 2'd0;
        w0 = we_total; a0 = ack_total;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1; D_WReq = 0; I_Req = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_abort_no_we", we_total - w0, 0);
        chk("rst_abort_no_ack", ack_total - a0, 0);
        streak_run(5, "post_rst", 10'b0000001111);

        repeat (2) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
